// File: rtl/timer_ctrl.sv
// Down-counting timer with one-shot/periodic modes, sticky irq and an optional prescaler.
// Define TIMER_CTRL_PRESCALE_EN to include the div_sel prescaler; otherwise the counter steps every RUN cycle.
module timer_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       div_sel,
    input  logic             irq_clr,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             irq
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic             oneshot_q;
    logic             pre_tick;
    logic             do_start;
    logic             expire;

    assign do_start = start && (load_val != '0);
    // Only an uncontested prescale tick at count==1 expires; stop and restart take priority.
    assign expire   = !stop && !do_start && (state == RUN) && pre_tick && (count == ONE);

`ifdef TIMER_CTRL_PRESCALE_EN
    logic [3:0] pre_cnt;
    logic [1:0] div_sel_q;

    function automatic logic [3:0] pre_max(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4'd1;
            2'd1:    return 4'd3;
            2'd2:    return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    assign pre_tick = (pre_cnt == pre_max(div_sel_q));

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            pre_cnt   <= '0;
            div_sel_q <= '0;
        end else if (stop) begin
            pre_cnt   <= '0;
        end else if (do_start) begin
            pre_cnt   <= '0;
            div_sel_q <= div_sel;
        end else if (state == RUN) begin
            pre_cnt   <= pre_tick ? 4'd0 : pre_cnt + 4'd1;
        end
    end
`else
    logic unused_div_sel;

    assign unused_div_sel = ^div_sel;
    assign pre_tick       = 1'b1;
`endif

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            oneshot_q  <= 1'b0;
            tick       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                count <= '0;
            end else if (do_start) begin
                state      <= RUN;
                busy       <= 1'b1;
                count      <= load_val;
                reload_reg <= load_val;
                oneshot_q  <= oneshot;
            end else if (state == RUN && pre_tick) begin
                if (count > ONE) begin
                    count <= count - ONE;
                end else begin
                    tick <= 1'b1;
                    if (oneshot_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else begin
                        count <= reload_reg;
                    end
                end
            end
        end
    end

    // A new expiry outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            irq <= 1'b0;
        end else if (expire) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl; expected timing scales with the prescale divisor of the build.
module tb_timer_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             arst;
    logic             start, stop, oneshot, irq_clr;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       div_sel;
    logic             tick, busy, irq;
    logic [WIDTH-1:0] count;

    int checks = 0;
    int errors = 0;

    timer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .arst(arst), .start(start), .stop(stop), .oneshot(oneshot),
        .load_val(load_val), .div_sel(div_sel), .irq_clr(irq_clr),
        .tick(tick), .busy(busy), .count(count), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic int dv(input logic [1:0] sel);
`ifdef TIMER_CTRL_PRESCALE_EN
        return 2 << sel;
`else
        return 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect exactly one tick, on the last of 'cycles' edges.
    task automatic expect_period(input string tag, input int cycles);
        for (int j = 1; j <= cycles; j++) begin
            step();
            chk(tag, {31'd0, tick}, (j == cycles) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic expect_no_tick(input string tag, input int cycles);
        for (int j = 0; j < cycles; j++) begin
            step();
            chk(tag, {30'd0, tick, busy}, 32'd0);
        end
    endtask

    initial begin
        int d;
        arst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
        irq_clr = 1'b0; load_val = '0; div_sel = 2'd0;
        #1 arst = 1'b0;
        #2;
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        #10 arst = 1'b1;
        step();
        chk("idle_after_rst", {31'd0, busy}, 32'd0);

        // One-shot, load 5
        d = dv(2'd0);
        start = 1'b1; oneshot = 1'b1; load_val = 16'd5; div_sel = 2'd0;
        step();
        start = 1'b0;
        chk("os_load_count", {16'd0, count}, 32'd5);
        chk("os_busy", {31'd0, busy}, 32'd1);
        for (int j = 1; j <= 5 * d; j++) begin
            step();
            chk("os_count", {16'd0, count}, (j < 5 * d) ? 32'(5 - j / d) : 32'd0);
            chk("os_tick", {31'd0, tick}, (j == 5 * d) ? 32'd1 : 32'd0);
        end
        chk("os_done_busy", {31'd0, busy}, 32'd0);
        chk("os_irq", {31'd0, irq}, 32'd1);
        step();
        chk("os_tick_once", {31'd0, tick}, 32'd0);
        chk("os_done_hold", {16'd0, count}, 32'd0);

        // irq clear alone
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        chk("irq_clr", {31'd0, irq}, 32'd0);

        // Periodic load 2; irq_clr held through the setting edge
        start = 1'b1; oneshot = 1'b0; load_val = 16'd2;
        step();
        start = 1'b0; irq_clr = 1'b1;
        expect_period("per2_tick1", 2 * d);
        chk("set_wins_irq", {31'd0, irq}, 32'd1);
        chk("per2_reload", {16'd0, count}, 32'd2);
        chk("per2_busy", {31'd0, busy}, 32'd1);
        step();
        irq_clr = 1'b0;
        chk("irq_clr_next", {31'd0, irq}, 32'd0);
        expect_period("per2_tick2", 2 * d - 1);

        // Restart with 7 while running
        start = 1'b1; load_val = 16'd7;
        step();
        start = 1'b0;
        chk("restart_count", {16'd0, count}, 32'd7);
        expect_period("restart_period", 7 * d);
        chk("restart_reload", {16'd0, count}, 32'd7);

        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_state", {15'd0, busy, count}, 32'd0);

        // Zero load ignored from IDLE
        start = 1'b1; load_val = 16'd0;
        step();
        start = 1'b0;
        chk("zero_load_ignored", {15'd0, busy, count}, 32'd0);

        // Periodic load 4, stop together with start at E2
        start = 1'b1; load_val = 16'd4;
        step();
        start = 1'b0;
        step();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("stop_wins", {15'd0, busy, count}, 32'd0);
        expect_no_tick("stop_no_tick", 4 * d + 2);

        // Async reset mid-count
        start = 1'b1; load_val = 16'd4;
        step();
        start = 1'b0;
        step();
        chk("pre_arst_busy", {31'd0, busy}, 32'd1);
        #2 arst = 1'b0;
        #1;
        chk("arst_outputs", {13'd0, tick, busy, irq, count}, 32'd0);
        #3 arst = 1'b1;
        expect_no_tick("arst_no_tick", 4 * d + 2);

        // Periodic load 3, div_sel 1
        d = dv(2'd1);
        start = 1'b1; load_val = 16'd3; div_sel = 2'd1;
        step();
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            expect_period("ps_period", 3 * d);
            chk("ps_busy", {31'd0, busy}, 32'd1);
            chk("ps_reload", {16'd0, count}, 32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the bit width of the load value and down-counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port arst, input, 1, the reset: asynchronous, active-low (0 = reset).
REQ-004 SHALL have port start, input, 1, a level sampled each edge that (re)starts the timer.
REQ-005 SHALL have port stop, input, 1, a level sampled each edge that aborts the timer.
REQ-006 SHALL have port oneshot, input, 1: 1 = one-shot, 0 = periodic; sampled at start.
REQ-007 SHALL have port load_val, input, WIDTH, the period in prescaled ticks; sampled at start.
REQ-008 SHALL have port div_sel, input, 2, the prescale select: divide by 2^(div_sel+1), i.e. 2/4/8/16; sampled at start.
REQ-009 SHALL have port irq_clr, input, 1, which clears irq.
REQ-010 SHALL have port tick, output, 1, a one-cycle pulse at each period expiry.
REQ-011 SHALL have port busy, output, 1, high while in RUN.
REQ-012 SHALL have port count, output, WIDTH, the current down-counter value.
REQ-013 SHALL have port irq, output, 1, a sticky expiry flag.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE; busy = (state == RUN).
REQ-015 On start with load_val != 0 in any state: count <= load_val, reload_reg <= load_val, latch oneshot and div_sel, pre_cnt <= 0, state <= RUN. This restarts the timer if it is already in RUN.
REQ-016 start with load_val == 0 SHALL be ignored, with no state change.
REQ-017 stop SHALL send state to IDLE and set count <= 0, with no tick and no irq; stop wins over a simultaneous start.
REQ-018 In RUN, pre_cnt (4 bits) SHALL increment every cycle and wrap to 0 when the prescale tick fires; the prescale tick fires when pre_cnt == 2^(div_sel_latched+1)-1.
REQ-019 On a prescale tick with count > 1, count SHALL decrement by 1.
REQ-020 On a prescale tick with count == 1, tick SHALL be registered high for exactly one cycle and irq set. Then, if periodic, count <= reload_reg and the state stays RUN. If one-shot, count <= 0 and state <= DONE.
REQ-021 Period: after start is sampled at edge E0, tick SHALL be high in the cycle following edge E0 + load_val*D, where D is the prescale divisor. In periodic mode tick SHALL repeat every load_val*D cycles with no gap cycles.
REQ-022 DONE SHALL hold count = 0 and busy = 0 until start (go to RUN) or stop (go to IDLE).
REQ-023 irq SHALL clear on irq_clr; if a set and irq_clr occur in the same cycle, the set wins.
REQ-024 count SHALL never underflow; count wraps only by reload.

Reset
REQ-025 While arst = 0, the block SHALL immediately force state = IDLE, count = 0, reload_reg = 0, pre_cnt = 0, tick = 0, busy = 0 and irq = 0, independent of clk.
REQ-026 Reset asserted mid-RUN SHALL abort without a tick; after release the block SHALL stay in IDLE until start.

Configuration
REQ-027 Macro TIMER_CTRL_PRESCALE_EN defined: the prescaler SHALL be present per REQ-018, with D = 2^(div_sel+1).
REQ-028 TIMER_CTRL_PRESCALE_EN undefined: the prescaler and pre_cnt SHALL be absent, the prescale tick SHALL fire every RUN cycle (D = 1), and div_sel SHALL be ignored.

Verification
REQ-029 Macro off, oneshot=1, load_val=5, start pulsed at E0 -> count 5,4,3,2,1; tick high one cycle after E5; irq=1; state DONE; count=0; busy=0.
REQ-030 Macro on, oneshot=0, load_val=3, div_sel=1 (D=4), start at E0 -> ticks after E12, E24 and E36; busy stays 1; count reloads to 3.
REQ-031 Periodic run with load_val=4 (macro off), stop asserted together with start at E2 -> IDLE, count=0, no tick ever.
REQ-032 Periodic run, arst driven low between edges mid-count -> all outputs 0 immediately; no tick after release until a new start.
REQ-033 irq_clr held high in the same cycle a tick sets irq -> irq=1; irq_clr the next cycle -> irq=0.
REQ-034 start with load_val=0 from IDLE -> stays IDLE; start with load_val=7 while in RUN -> count=7 and the period restarts.
